sal_timing_cfg: RTL and testbench

SAL_TIMING_CFG -- requirements
Module: SAL_TIMING_CFG

---
 rtl/sal_timing_cfg.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_sal_timing_cfg.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sal_timing_cfg.sv
// sal_timing_cfg: APB-programmable DRAM timing configuration for NUM_CH channels.
// APB writes go to a shadow register set per channel. A COMMIT in CTRL arms a
// channel; the shadow set is copied into the active set once that channel's
// controller reports idle. The active set drives the timing outputs.

`ifndef T_RCD_VALUE_M1
`define T_RCD_VALUE_M1 13
`endif
`ifndef T_RP_VALUE_M1
`define T_RP_VALUE_M1 13
`endif
`ifndef T_RAS_VALUE_M1
`define T_RAS_VALUE_M1 31
`endif
`ifndef T_RFC_VALUE_M1
`define T_RFC_VALUE_M1 207
`endif
`ifndef T_RTP_VALUE_M1
`define T_RTP_VALUE_M1 7
`endif
`ifndef T_WTP_VALUE_M1
`define T_WTP_VALUE_M1 19
`endif
`ifndef T_RRD_VALUE_M1
`define T_RRD_VALUE_M1 5
`endif
`ifndef T_CCD_VALUE_M1
`define T_CCD_VALUE_M1 3
`endif
`ifndef T_WTR_VALUE_M1
`define T_WTR_VALUE_M1 7
`endif
`ifndef T_RTW_VALUE_M1
`define T_RTW_VALUE_M1 9
`endif
`ifndef WRITE_LATENCY
`define WRITE_LATENCY 5
`endif

module sal_timing_cfg #(
    parameter int NUM_CH = 2,
    parameter int TW     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   psel,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [11:0]            paddr,
    input  logic [31:0]            pwdata,
    output logic [31:0]            prdata,
    output logic                   pready,
    output logic                   pslverr,
    input  logic [NUM_CH-1:0]      ctrl_idle,
    output logic [NUM_CH*TW-1:0]   t_rcd_m1,
    output logic [NUM_CH*TW-1:0]   t_rp_m1,
    output logic [NUM_CH*TW-1:0]   t_ras_m1,
    output logic [NUM_CH*TW-1:0]   t_rfc_m1,
    output logic [NUM_CH*TW-1:0]   t_rtp_m1,
    output logic [NUM_CH*TW-1:0]   t_wtp_m1,
    output logic [NUM_CH*TW-1:0]   t_rrd_m1,
    output logic [NUM_CH*TW-1:0]   t_ccd_m1,
    output logic [NUM_CH*TW-1:0]   t_wtr_m1,
    output logic [NUM_CH*TW-1:0]   t_rtw_m1,
    output logic [NUM_CH*4-1:0]    dfi_wren_lat,
    output logic [NUM_CH*4-1:0]    dfi_rden_lat,
    output logic [NUM_CH-1:0]      cfg_upd
);

    localparam int DEF_RCD   = `T_RCD_VALUE_M1;
    localparam int DEF_RP    = `T_RP_VALUE_M1;
    localparam int DEF_RAS   = `T_RAS_VALUE_M1;
    localparam int DEF_RFC   = `T_RFC_VALUE_M1;
    localparam int DEF_RTP   = `T_RTP_VALUE_M1;
    localparam int DEF_WTP   = `T_WTP_VALUE_M1;
    localparam int DEF_RRD   = `T_RRD_VALUE_M1;
    localparam int DEF_CCD   = `T_CCD_VALUE_M1;
    localparam int DEF_WTR   = `T_WTR_VALUE_M1;
    localparam int DEF_RTW   = `T_RTW_VALUE_M1;
    localparam int DEF_WREN  = `WRITE_LATENCY;
    localparam int DEF_RDEN  = 6;

    localparam logic [31:0] VERSION = 32'h0001_0000 | (32'(NUM_CH) << 8) | 32'(TW);

    typedef struct packed {
        logic [TW-1:0] rcd;
        logic [TW-1:0] rp;
        logic [TW-1:0] ras;
        logic [TW-1:0] rfc;
        logic [TW-1:0] rtp;
        logic [TW-1:0] wtp;
        logic [TW-1:0] rrd;
        logic [TW-1:0] ccd;
        logic [TW-1:0] wtr;
        logic [TW-1:0] rtw;
        logic [3:0]    wren;
        logic [3:0]    rden;
    } timing_t;

    function automatic timing_t default_timing();
        timing_t t;
        t.rcd  = TW'(DEF_RCD);
        t.rp   = TW'(DEF_RP);
        t.ras  = TW'(DEF_RAS);
        t.rfc  = TW'(DEF_RFC);
        t.rtp  = TW'(DEF_RTP);
        t.wtp  = TW'(DEF_WTP);
        t.rrd  = TW'(DEF_RRD);
        t.ccd  = TW'(DEF_CCD);
        t.wtr  = TW'(DEF_WTR);
        t.rtw  = TW'(DEF_RTW);
        t.wren = 4'(DEF_WREN);
        t.rden = 4'(DEF_RDEN);
        return t;
    endfunction

    // Each field sits in the low bits of its byte; the remaining bits read as zero.
    function automatic logic [31:0] pack_word(timing_t s, logic [5:0] off);
        logic [31:0] w;
        w = '0;
        case (off)
            6'h00: begin
                w[0  +: TW] = s.rcd;
                w[8  +: TW] = s.rp;
                w[16 +: TW] = s.ras;
                w[24 +: TW] = s.rfc;
            end
            6'h04: begin
                w[0  +: TW] = s.rtp;
                w[8  +: TW] = s.wtp;
                w[16 +: TW] = s.rrd;
                w[24 +: TW] = s.ccd;
            end
            6'h08: begin
                w[0  +: TW] = s.wtr;
                w[8  +: TW] = s.rtw;
                w[19:16]    = s.wren;
                w[27:24]    = s.rden;
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic timing_t merge_word(timing_t cur, logic [5:0] off, logic [31:0] w);
        timing_t r;
        r = cur;
        case (off)
            6'h00: begin
                r.rcd = w[0  +: TW];
                r.rp  = w[8  +: TW];
                r.ras = w[16 +: TW];
                r.rfc = w[24 +: TW];
            end
            6'h04: begin
                r.rtp = w[0  +: TW];
                r.wtp = w[8  +: TW];
                r.rrd = w[16 +: TW];
                r.ccd = w[24 +: TW];
            end
            6'h08: begin
                r.wtr  = w[0 +: TW];
                r.rtw  = w[8 +: TW];
                r.wren = w[19:16];
                r.rden = w[27:24];
            end
            default: r = cur;
        endcase
        return r;
    endfunction

    timing_t           shadow [NUM_CH];
    timing_t           active [NUM_CH];
    logic [NUM_CH-1:0] pending;

    logic              access;
    logic              is_ctrl;
    logic              is_ver;
    logic [5:0]        off;
    logic              off_ok;
    logic [NUM_CH-1:0] blk_hit;
    logic              blk_pend;
    logic [31:0]       blk_rdata;
    logic [31:0]       ctrl_rdata;
    logic [31:0]       rdata;
    logic              err;
    logic              ctrl_we;
    logic              wr_ok;
    logic [NUM_CH-1:0] copy;
    logic [NUM_CH-1:0] pending_nxt;
    logic [NUM_CH-1:0] shadow_we;

    // Decode the APB access: target register, read data and error response.
    always_comb begin
        access     = psel & penable;
        is_ctrl    = (paddr == 12'h000);
        is_ver     = (paddr == 12'h004);
        off        = paddr[5:0];
        off_ok     = (off == 6'h00) || (off == 6'h04) || (off == 6'h08);
        blk_hit    = '0;
        blk_pend   = 1'b0;
        blk_rdata  = '0;
        ctrl_rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ctrl_rdata[8+c] = pending[c];
            if (paddr[11:6] == 6'(c + 1)) begin
                blk_hit[c] = 1'b1;
                blk_pend   = pending[c];
                blk_rdata  = pack_word(shadow[c], off);
            end
        end
        if (!access)
            err = 1'b0;
        else if (is_ctrl)
            err = 1'b0;
        else if (is_ver)
            err = pwrite;
        else if ((|blk_hit) && off_ok)
            err = pwrite & blk_pend;
        else
            err = 1'b1;
        if (is_ctrl)
            rdata = ctrl_rdata;
        else if (is_ver)
            rdata = VERSION;
        else
            rdata = blk_rdata;
        prdata  = (access && !err && !rst) ? rdata : '0;
        pslverr = access && err && !rst;
        pready  = access;
    end

    // Per-channel commit/abort arbitration and shadow write enables.
    always_comb begin
        ctrl_we     = access & pwrite & is_ctrl;
        wr_ok       = access & pwrite & ~err;
        copy        = '0;
        pending_nxt = pending;
        shadow_we   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            copy[c] = pending[c] & ctrl_idle[c] & ~(ctrl_we & pwdata[16+c]);
            if (ctrl_we && pwdata[16+c])
                pending_nxt[c] = 1'b0;
            else if (copy[c])
                pending_nxt[c] = 1'b0;
            else if (ctrl_we && pwdata[c])
                pending_nxt[c] = 1'b1;
            shadow_we[c] = wr_ok & blk_hit[c] & off_ok;
        end
    end

    // Shadow/active register sets, pending flags and the update pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                shadow[c] <= default_timing();
                active[c] <= default_timing();
            end
            pending <= '0;
            cfg_upd <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (copy[c])
                    active[c] <= shadow[c];
                if (shadow_we[c])
                    shadow[c] <= merge_word(shadow[c], off, pwdata);
            end
            pending <= pending_nxt;
            cfg_upd <= copy;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign t_rcd_m1[g*TW +: TW]   = active[g].rcd;
        assign t_rp_m1[g*TW +: TW]    = active[g].rp;
        assign t_ras_m1[g*TW +: TW]   = active[g].ras;
        assign t_rfc_m1[g*TW +: TW]   = active[g].rfc;
        assign t_rtp_m1[g*TW +: TW]   = active[g].rtp;
        assign t_wtp_m1[g*TW +: TW]   = active[g].wtp;
        assign t_rrd_m1[g*TW +: TW]   = active[g].rrd;
        assign t_ccd_m1[g*TW +: TW]   = active[g].ccd;
        assign t_wtr_m1[g*TW +: TW]   = active[g].wtr;
        assign t_rtw_m1[g*TW +: TW]   = active[g].rtw;
        assign dfi_wren_lat[g*4 +: 4] = active[g].wren;
        assign dfi_rden_lat[g*4 +: 4] = active[g].rden;
    end

endmodule

// File: tb/tb_sal_timing_cfg.sv
// Directed testbench for sal_timing_cfg (NUM_CH=2, TW=8) with default
// reset values rcd/rp=0x0D, ras=0x1F, rfc=0xCF, rtp=7, wtp=0x13, rrd=5,
// ccd=3, wtr=7, rtw=9, wren=5, rden=6.
module tb_sal_timing_cfg;

    localparam int NUM_CH = 2;
    localparam int TW     = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 psel, penable, pwrite;
    logic [11:0]          paddr;
    logic [31:0]          pwdata;
    logic [31:0]          prdata;
    logic                 pready, pslverr;
    logic [NUM_CH-1:0]    ctrl_idle;
    logic [NUM_CH*TW-1:0] t_rcd_m1, t_rp_m1, t_ras_m1, t_rfc_m1, t_rtp_m1;
    logic [NUM_CH*TW-1:0] t_wtp_m1, t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1;
    logic [NUM_CH*4-1:0]  dfi_wren_lat, dfi_rden_lat;
    logic [NUM_CH-1:0]    cfg_upd;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] rd;
    logic        er;
    logic        rdy;

    always #5 clk = ~clk;

    sal_timing_cfg #(.NUM_CH(NUM_CH), .TW(TW)) dut (
        .clk(clk), .rst(rst),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .ctrl_idle(ctrl_idle),
        .t_rcd_m1(t_rcd_m1), .t_rp_m1(t_rp_m1), .t_ras_m1(t_ras_m1), .t_rfc_m1(t_rfc_m1),
        .t_rtp_m1(t_rtp_m1), .t_wtp_m1(t_wtp_m1), .t_rrd_m1(t_rrd_m1), .t_ccd_m1(t_ccd_m1),
        .t_wtr_m1(t_wtr_m1), .t_rtw_m1(t_rtw_m1),
        .dfi_wren_lat(dfi_wren_lat), .dfi_rden_lat(dfi_rden_lat), .cfg_upd(cfg_upd)
    );

    // Two-phase APB write starting and ending on a falling edge; error sampled late in access phase.
    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic e);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        #4;
        e = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a; pwdata = '0;
        @(negedge clk);
        penable = 1'b1;
        #4;
        d = prdata; e = pslverr; rdy = pready;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ctrl_idle = '0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (prdata !== 32'h0) begin n_bad++; $display("[TB] FAIL rst_prdata got %h want 0", prdata); end
        n_cmp++; if (pslverr !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_pslverr got %b want 0", pslverr); end
        n_cmp++; if (cfg_upd !== 2'b00) begin n_bad++; $display("[TB] FAIL rst_cfg_upd got %b want 00", cfg_upd); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (t_rcd_m1 !== 16'h0D0D) begin n_bad++; $display("[TB] FAIL rst_rcd got %h want 0d0d", t_rcd_m1); end
        n_cmp++; if (t_rfc_m1 !== 16'hCFCF) begin n_bad++; $display("[TB] FAIL rst_rfc got %h want cfcf", t_rfc_m1); end
        n_cmp++; if (t_wtp_m1 !== 16'h1313) begin n_bad++; $display("[TB] FAIL rst_wtp got %h want 1313", t_wtp_m1); end
        n_cmp++; if (dfi_wren_lat !== 8'h55) begin n_bad++; $display("[TB] FAIL rst_wren got %h want 55", dfi_wren_lat); end
        n_cmp++; if (dfi_rden_lat !== 8'h66) begin n_bad++; $display("[TB] FAIL rst_rden got %h want 66", dfi_rden_lat); end
        apb_read(12'h040, rd, er);
        n_cmp++; if (rd !== 32'hCF1F0D0D || er !== 1'b0) begin n_bad++; $display("[TB] FAIL rd_ch0_w0 got %h err %b want cf1f0d0d err 0", rd, er); end
        n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("[TB] FAIL pready got %b want 1", rdy); end
        apb_read(12'h044, rd, er);
        n_cmp++; if (rd !== 32'h03051307 || er !== 1'b0) begin n_bad++; $display("[TB] FAIL rd_ch0_w1 got %h err %b want 03051307 err 0", rd, er); end
        apb_read(12'h048, rd, er);
        n_cmp++; if (rd !== 32'h06050907 || er !== 1'b0) begin n_bad++; $display("[TB] FAIL rd_ch0_w2 got %h err %b want 06050907 err 0", rd, er); end
        apb_read(12'h004, rd, er);
        n_cmp++; if (rd !== 32'h00010208 || er !== 1'b0) begin n_bad++; $display("[TB] FAIL rd_version got %h err %b want 00010208 err 0", rd, er); end
        apb_read(12'h000, rd, er);
        n_cmp++; if (rd !== 32'h0 || er !== 1'b0) begin n_bad++; $display("[TB] FAIL rd_ctrl_rst got %h err %b want 0 err 0", rd, er); end
    endtask

    task automatic test_commit_idle();
        ctrl_idle = 2'b00;
        apb_write(12'h040, 32'h20100C0A, er);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("[TB] FAIL wr_ch0_w0 err got %b want 0", er); end
        apb_write(12'h000, 32'h1, er);
        apb_read(12'h000, rd, er);
        n_cmp++; if (rd !== 32'h100) begin n_bad++; $display("[TB] FAIL ctrl_pending got %h want 100", rd); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++; if (t_rcd_m1[7:0] !== 8'h0D || cfg_upd !== 2'b00) begin n_bad++; $display("[TB] FAIL wait_busy[%0d] rcd %h upd %b want 0d 00", i, t_rcd_m1[7:0], cfg_upd); end
        end
        ctrl_idle = 2'b01;
        #1;
        n_cmp++; if (t_rcd_m1[7:0] !== 8'h0D) begin n_bad++; $display("[TB] FAIL idle_edge_rcd got %h want 0d", t_rcd_m1[7:0]); end
        @(negedge clk);
        n_cmp++; if (t_rcd_m1 !== 16'h0D0A) begin n_bad++; $display("[TB] FAIL commit_rcd got %h want 0d0a", t_rcd_m1); end
        n_cmp++; if (t_rp_m1[7:0] !== 8'h0C || t_ras_m1[7:0] !== 8'h10 || t_rfc_m1[7:0] !== 8'h20) begin n_bad++; $display("[TB] FAIL commit_rp_ras_rfc got %h %h %h want 0c 10 20", t_rp_m1[7:0], t_ras_m1[7:0], t_rfc_m1[7:0]); end
        n_cmp++; if (cfg_upd !== 2'b01) begin n_bad++; $display("[TB] FAIL commit_upd got %b want 01", cfg_upd); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (cfg_upd !== 2'b00) begin n_bad++; $display("[TB] FAIL upd_once[%0d] got %b want 00", i, cfg_upd); end
        end
        apb_read(12'h000, rd, er);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("[TB] FAIL ctrl_cleared got %h want 0", rd); end
    endtask

    task automatic test_pending_lock();
        ctrl_idle = 2'b00;
        apb_write(12'h000, 32'h1, er);
        apb_write(12'h044, 32'h11223344, er);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("[TB] FAIL wr_locked err got %b want 1", er); end
        apb_read(12'h044, rd, er);
        n_cmp++; if (rd !== 32'h03051307 || er !== 1'b0) begin n_bad++; $display("[TB] FAIL locked_shadow got %h err %b want 03051307 0", rd, er); end
        apb_write(12'h084, 32'h11223344, er);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("[TB] FAIL wr_ch1 err got %b want 0", er); end
        apb_read(12'h084, rd, er);
        n_cmp++; if (rd !== 32'h11223344) begin n_bad++; $display("[TB] FAIL rd_ch1_w1 got %h want 11223344", rd); end
        apb_write(12'h088, 32'hFFFFFFFF, er);
        apb_read(12'h088, rd, er);
        n_cmp++; if (rd !== 32'h0F0FFFFF) begin n_bad++; $display("[TB] FAIL rd_ch1_w2 got %h want 0f0fffff", rd); end
        apb_write(12'h000, 32'h10000, er);
        apb_read(12'h000, rd, er);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("[TB] FAIL abort_clear got %h want 0", rd); end
        n_cmp++; if (t_rcd_m1 !== 16'h0D0A || t_rtp_m1 !== 16'h0707) begin n_bad++; $display("[TB] FAIL abort_nocopy rcd %h rtp %h want 0d0a 0707", t_rcd_m1, t_rtp_m1); end
    endtask

    task automatic test_abort_and_multi();
        ctrl_idle = 2'b11;
        repeat (2) @(negedge clk);
        apb_write(12'h000, 32'h10001, er);
        n_cmp++; if (cfg_upd !== 2'b00) begin n_bad++; $display("[TB] FAIL abort_win_upd0 got %b want 00", cfg_upd); end
        @(negedge clk);
        n_cmp++; if (cfg_upd !== 2'b00) begin n_bad++; $display("[TB] FAIL abort_win_upd1 got %b want 00", cfg_upd); end
        apb_read(12'h000, rd, er);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("[TB] FAIL abort_win_ctrl got %h want 0", rd); end
        apb_write(12'h000, 32'h3, er);
        n_cmp++; if (t_rtp_m1 !== 16'h0707 || cfg_upd !== 2'b00) begin n_bad++; $display("[TB] FAIL no_early_commit rtp %h upd %b want 0707 00", t_rtp_m1, cfg_upd); end
        @(negedge clk);
        n_cmp++; if (cfg_upd !== 2'b11) begin n_bad++; $display("[TB] FAIL dual_upd got %b want 11", cfg_upd); end
        n_cmp++; if (t_rtp_m1 !== 16'h4407 || t_ccd_m1 !== 16'h1103) begin n_bad++; $display("[TB] FAIL dual_rtp_ccd got %h %h want 4407 1103", t_rtp_m1, t_ccd_m1); end
        n_cmp++; if (dfi_wren_lat !== 8'hF5 || dfi_rden_lat !== 8'hF6) begin n_bad++; $display("[TB] FAIL dual_lat got %h %h want f5 f6", dfi_wren_lat, dfi_rden_lat); end
        n_cmp++; if (t_rtw_m1 !== 16'hFF09 || t_wtr_m1 !== 16'hFF07) begin n_bad++; $display("[TB] FAIL dual_rtw_wtr got %h %h want ff09 ff07", t_rtw_m1, t_wtr_m1); end
        n_cmp++; if (t_rcd_m1 !== 16'h0D0A) begin n_bad++; $display("[TB] FAIL dual_rcd got %h want 0d0a", t_rcd_m1); end
        @(negedge clk);
        n_cmp++; if (cfg_upd !== 2'b00) begin n_bad++; $display("[TB] FAIL dual_upd_end got %b want 00", cfg_upd); end
    endtask

    task automatic test_errors();
        apb_read(12'h0C0, rd, er);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("[TB] FAIL err_ch2 err %b rd %h want 1 0", er, rd); end
        apb_read(12'h010, rd, er);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("[TB] FAIL err_unmapped err %b rd %h want 1 0", er, rd); end
        apb_read(12'h04C, rd, er);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("[TB] FAIL err_off_c err %b rd %h want 1 0", er, rd); end
        apb_write(12'h004, 32'hFFFFFFFF, er);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("[TB] FAIL err_wr_version err %b want 1", er); end
        apb_read(12'h004, rd, er);
        n_cmp++; if (rd !== 32'h00010208 || er !== 1'b0) begin n_bad++; $display("[TB] FAIL version_after got %h err %b want 00010208 0", rd, er); end
    endtask

    task automatic test_reset_pending();
        ctrl_idle = 2'b00;
        apb_write(12'h080, 32'h55555555, er);
        apb_write(12'h000, 32'h2, er);
        apb_read(12'h000, rd, er);
        n_cmp++; if (rd !== 32'h200) begin n_bad++; $display("[TB] FAIL pend1 got %h want 200", rd); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; ctrl_idle = 2'b11;
        @(negedge clk);
        n_cmp++; if (t_rcd_m1 !== 16'h0D0D || t_rtp_m1 !== 16'h0707 || t_rtw_m1 !== 16'h0909) begin n_bad++; $display("[TB] FAIL rst2_timing rcd %h rtp %h rtw %h want 0d0d 0707 0909", t_rcd_m1, t_rtp_m1, t_rtw_m1); end
        n_cmp++; if (dfi_wren_lat !== 8'h55 || dfi_rden_lat !== 8'h66) begin n_bad++; $display("[TB] FAIL rst2_lat got %h %h want 55 66", dfi_wren_lat, dfi_rden_lat); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (cfg_upd !== 2'b00 || t_rfc_m1 !== 16'hCFCF) begin n_bad++; $display("[TB] FAIL rst2_quiet[%0d] upd %b rfc %h want 00 cfcf", i, cfg_upd, t_rfc_m1); end
            @(negedge clk);
        end
        apb_read(12'h000, rd, er);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("[TB] FAIL rst2_ctrl got %h want 0", rd); end
        apb_read(12'h080, rd, er);
        n_cmp++; if (rd !== 32'hCF1F0D0D) begin n_bad++; $display("[TB] FAIL rst2_shadow got %h want cf1f0d0d", rd); end
        apb_read(12'h084, rd, er);
        n_cmp++; if (rd !== 32'h03051307) begin n_bad++; $display("[TB] FAIL rst2_shadow_w1 got %h want 03051307", rd); end
    endtask

    // Run every scenario in order, then report totals.
    initial begin
        test_reset();
        test_commit_idle();
        test_pending_lock();
        test_abort_and_multi();
        test_errors();
        test_reset_pending();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
